mist32e_memory_arbiter: RTL

//  Two-master arbiter for the single-port external memory bus. M0 = boot/loader (IBOOT) port, M1 = processor core.

---
 rtl/mist32e_memarb_pkg.sv | 9 +
 rtl/mist32e_memarb_tag_fifo.sv | 60 ++++++
 rtl/mist32e_memory_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mist32e_memarb_pkg.sv
// Shared types and master identifiers for the external memory bus arbiter.
package mist32e_memarb_pkg;

    typedef logic master_id_t;

    localparam master_id_t MEMARB_M_BOOT = 1'b0;
    localparam master_id_t MEMARB_M_CORE = 1'b1;

endpackage

// File: rtl/mist32e_memarb_tag_fifo.sv
// Owner-tag FIFO: remembers which master issued each outstanding read so the
// returned data can be routed back in issue order.
module mist32e_memarb_tag_fifo
    import mist32e_memarb_pkg::*;
#(
    parameter int P_TAG_DEPTH = 4
) (
    input  logic       iCLOCK,
    input  logic       inRESET,
    input  logic       iCLEAR,
    input  logic       iPUSH,
    input  master_id_t iPUSH_ID,
    input  logic       iPOP,
    output logic       oFULL,
    output logic       oEMPTY,
    output master_id_t oHEAD
);

    localparam int PTR_W = $clog2(P_TAG_DEPTH);

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    master_id_t       tagMem [P_TAG_DEPTH];
    logic             doPush;
    logic             doPop;

    assign oFULL  = (count == (PTR_W+1)'(P_TAG_DEPTH));
    assign oEMPTY = (count == '0);
    assign oHEAD  = tagMem[rdPtr];
    assign doPush = iPUSH && !oFULL;
    assign doPop  = iPOP && !oEMPTY;

    // Pointers and occupancy; both pointers wrap naturally at the depth.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (iCLEAR) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge iCLOCK) begin
        if (doPush) tagMem[wrPtr] <= iPUSH_ID;
    end

endmodule

// File: rtl/mist32e_memory_arbiter.sv
// Two-master cycle-by-cycle arbiter for the single-port external memory bus.
// M0 is the boot loader, M1 the core; read returns are routed by owner tag.
module mist32e_memory_arbiter
    import mist32e_memarb_pkg::*;
#(
    parameter int P_TAG_DEPTH = 4,
    parameter int P_FIXED_PRI = 0
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iM0_REQ,
    output logic        oM0_LOCK,
    input  logic [3:0]  iM0_MASK,
    input  logic        iM0_RW,
    input  logic [31:0] iM0_ADDR,
    input  logic [31:0] iM0_DATA,
    output logic        oM0_VALID,
    input  logic        iM0_BUSY,
    output logic [63:0] oM0_DATA,
    input  logic        iM1_REQ,
    output logic        oM1_LOCK,
    input  logic [3:0]  iM1_MASK,
    input  logic        iM1_RW,
    input  logic [31:0] iM1_ADDR,
    input  logic [31:0] iM1_DATA,
    output logic        oM1_VALID,
    input  logic        iM1_BUSY,
    output logic [63:0] oM1_DATA,
    output logic        oMEMORY_REQ,
    input  logic        iMEMORY_BUSY,
    output logic [3:0]  oMEMORY_MASK,
    output logic        oMEMORY_RW,
    output logic [31:0] oMEMORY_ADDR,
    output logic [31:0] oMEMORY_DATA,
    input  logic        iMEMORY_VALID,
    output logic        oMEMORY_BUSY,
    input  logic [63:0] iMEMORY_DATA,
    output logic        oERR_UNDERFLOW
);

    master_id_t rrPtr;
    master_id_t grant;
    master_id_t head;
    logic       resetActive;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       elig0;
    logic       elig1;
    logic       accept;
    logic       push;
    logic       pop;
    logic       headBusy;

    // Outputs that must stay quiet while either reset is asserted.
    assign resetActive = !inRESET || iRESET_SYNC;

    // A read cannot be taken while every tag slot is occupied.
    assign elig0 = iM0_REQ && !(!iM0_RW && fifoFull);
    assign elig1 = iM1_REQ && !(!iM1_RW && fifoFull);

    // Grant selection and request field mux.
    always_comb begin
        grant = MEMARB_M_BOOT;
        if (elig0 && elig1) begin
            grant = (P_FIXED_PRI != 0) ? MEMARB_M_BOOT : rrPtr;
        end else if (elig1) begin
            grant = MEMARB_M_CORE;
        end
        oMEMORY_REQ  = (elig0 || elig1) && !resetActive;
        oMEMORY_MASK = (grant == MEMARB_M_CORE) ? iM1_MASK : iM0_MASK;
        oMEMORY_RW   = (grant == MEMARB_M_CORE) ? iM1_RW   : iM0_RW;
        oMEMORY_ADDR = (grant == MEMARB_M_CORE) ? iM1_ADDR : iM0_ADDR;
        oMEMORY_DATA = (grant == MEMARB_M_CORE) ? iM1_DATA : iM0_DATA;
    end

    assign accept   = oMEMORY_REQ && !iMEMORY_BUSY;
    assign oM0_LOCK = iM0_REQ && !(accept && grant == MEMARB_M_BOOT);
    assign oM1_LOCK = iM1_REQ && !(accept && grant == MEMARB_M_CORE);
    assign push     = accept && !oMEMORY_RW;

    // Return routing: the FIFO head names the owner of the next read data.
    assign headBusy     = (head == MEMARB_M_CORE) ? iM1_BUSY : iM0_BUSY;
    assign oMEMORY_BUSY = !fifoEmpty && headBusy;
    assign pop          = iMEMORY_VALID && !fifoEmpty && !headBusy;
    assign oM0_VALID    = iMEMORY_VALID && !fifoEmpty && !resetActive && (head == MEMARB_M_BOOT);
    assign oM1_VALID    = iMEMORY_VALID && !fifoEmpty && !resetActive && (head == MEMARB_M_CORE);
    assign oM0_DATA     = iMEMORY_DATA;
    assign oM1_DATA     = iMEMORY_DATA;

    // Round-robin pointer moves to the non-granted master after each accept.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rrPtr <= MEMARB_M_BOOT;
        end else if (iRESET_SYNC) begin
            rrPtr <= MEMARB_M_BOOT;
        end else if (accept && P_FIXED_PRI == 0) begin
            rrPtr <= ~grant;
        end
    end

    // Sticky flag for read data arriving with no outstanding owner.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oERR_UNDERFLOW <= 1'b0;
        end else if (iRESET_SYNC) begin
            oERR_UNDERFLOW <= 1'b0;
        end else if (iMEMORY_VALID && fifoEmpty) begin
            oERR_UNDERFLOW <= 1'b1;
        end
    end

    mist32e_memarb_tag_fifo #(
        .P_TAG_DEPTH(P_TAG_DEPTH)
    ) uTagFifo (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .iCLEAR  (iRESET_SYNC),
        .iPUSH   (push),
        .iPUSH_ID(grant),
        .iPOP    (pop),
        .oFULL   (fifoFull),
        .oEMPTY  (fifoEmpty),
        .oHEAD   (head)
    );

endmodule
